// File: rtl/ctrl_iload.sv
// ctrl_iload -- program loader for the controller instruction memory.
//
// Accepts decoded instruction fields over a valid/ready stream, packs them into
// one INSTRWIDTH word (the same layout ctrl_ifetch unpacks) and writes them to
// sequential instruction RAM addresses 0..last_addr.
//
// Ports:
//   clk, rst (async, active-low)
//   start, last_addr, abort       : load control (start sampled in IDLE only)
//   in_valid / in_ready           : instruction field stream handshake
//   lstg_f, upse_f, vector_id, result_reg, error_reg,
//   data_uptr, data_lptr, coef_ptr: instruction fields
//   imem_we, imem_addr, imem_wdata: registered instruction RAM write port
//   busy                          : high while in LOAD
//   done                          : one-cycle pulse once the program is written
//   chk_sum                       : XOR of all accepted words (only with
//                                   CTRL_ILOAD_CHKSUM_EN defined)
//
// Optional feature macro: CTRL_ILOAD_CHKSUM_EN
module ctrl_iload #(
  parameter int VIDWIDTH = 5,
  parameter int RFAWIDTH = 5,
  parameter int DAWIDTH  = 12,
  parameter int IAWIDTH  = 6,
  localparam int INSTRWIDTH = 2 + VIDWIDTH + 2*RFAWIDTH + 3*DAWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IAWIDTH-1:0]    last_addr,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  lstg_f,
  input  logic                  upse_f,
  input  logic [VIDWIDTH-1:0]   vector_id,
  input  logic [RFAWIDTH-1:0]   result_reg,
  input  logic [RFAWIDTH-1:0]   error_reg,
  input  logic [DAWIDTH-1:0]    data_uptr,
  input  logic [DAWIDTH-1:0]    data_lptr,
  input  logic [DAWIDTH-1:0]    coef_ptr,
  output logic                  imem_we,
  output logic [IAWIDTH-1:0]    imem_addr,
  output logic [INSTRWIDTH-1:0] imem_wdata,
  output logic                  busy,
`ifdef CTRL_ILOAD_CHKSUM_EN
  output logic [INSTRWIDTH-1:0] chk_sum,
`endif
  output logic                  done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IAWIDTH-1:0]    addr_q, addr_d;
  logic [IAWIDTH-1:0]    last_q, last_d;
  logic                  we_q, we_d;
  logic [IAWIDTH-1:0]    waddr_q, waddr_d;
  logic [INSTRWIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic [INSTRWIDTH-1:0] packed_word;

  // lstg_f at MSB, coef_ptr at LSB
  assign packed_word = {lstg_f, upse_f, vector_id, result_reg, error_reg,
                        data_uptr, data_lptr, coef_ptr};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          last_d  = last_addr;
        end
      end
      LOAD: begin
        in_ready = !abort;
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          accept  = 1'b1;
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = packed_word;
          addr_d  = addr_q + IAWIDTH'(1);
          if (addr_q == last_q) state_d = DONE;
        end
      end
      DONE: begin
        // done is registered, so the pulse lands the cycle after the final write
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign busy       = (state_q == LOAD);

`ifdef CTRL_ILOAD_CHKSUM_EN
  logic [INSTRWIDTH-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (state_q == IDLE && start) chk_d = '0;
    if (accept)                   chk_d = chk_q ^ packed_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chk_q <= '0;
    else      chk_q <= chk_d;
  end

  assign chk_sum = chk_q;
`endif

endmodule
